// File: rtl/alu16_seq_65ce02.sv
// Runs 16-bit word ops as two byte passes through the shared 8-bit 65CE02 ALU.
// Build option: define ALU16_SEQ_ASR_EN to decode cmd 8 as ASR (otherwise NOP).
module alu16_seq_65ce02 (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  input  logic        c_in,
  output logic [3:0]  alu_op,
  output logic        alu_right,
  output logic        alu_arith,
  output logic [7:0]  alu_ai,
  output logic [7:0]  alu_bi,
  output logic        alu_ci,
  input  logic [7:0]  alu_out,
  input  logic        alu_co,
  input  logic        alu_v,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        c_out,
  output logic        v_out,
  output logic        n_out,
  output logic        z_out
);

  typedef enum logic [1:0] {IDLE, S0, S1, S2} state_t;

  state_t      state, state_next;

  logic [3:0]  cmd_q;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        c_q;
  logic [7:0]  byte0_q;

  logic [3:0]  dec_op;
  logic        dec_addsub;
  logic        dec_use_b;
  logic        dec_right;
  logic        dec_asr;
  logic        dec_nop;
  logic        dec_ci0;

  logic        hi_sel;
  logic [15:0] word;
  logic        word_c;
  logic        word_v;

  // Command decode from the latched command and carry.
  always_comb begin
    dec_op     = 4'b1111;
    dec_addsub = 1'b0;
    dec_use_b  = 1'b0;
    dec_right  = 1'b0;
    dec_asr    = 1'b0;
    dec_nop    = 1'b0;
    dec_ci0    = 1'b0;
    case (cmd_q)
      4'd0: begin
        dec_op     = 4'b0011;
        dec_addsub = 1'b1;
        dec_use_b  = 1'b1;
        dec_ci0    = c_q;
      end
      4'd1: begin
        dec_op     = 4'b0111;
        dec_addsub = 1'b1;
        dec_use_b  = 1'b1;
        dec_ci0    = c_q;
      end
      4'd2: begin
        dec_op  = 4'b0011;
        dec_ci0 = 1'b1;
      end
      4'd3: begin
        dec_op  = 4'b0111;
        dec_ci0 = 1'b0;
      end
      4'd4: begin
        dec_op  = 4'b1011;
        dec_ci0 = 1'b0;
      end
      4'd5: begin
        dec_op  = 4'b1011;
        dec_ci0 = c_q;
      end
      4'd6: begin
        dec_right = 1'b1;
        dec_ci0   = 1'b0;
      end
      4'd7: begin
        dec_right = 1'b1;
        dec_ci0   = c_q;
      end
`ifdef ALU16_SEQ_ASR_EN
      4'd8: begin
        dec_right = 1'b1;
        dec_asr   = 1'b1;
        dec_ci0   = 1'b0;
      end
`endif
      default: dec_nop = 1'b1;
    endcase
  end

  // Right shifts walk the word high byte first so the carry moves downward.
  always_comb begin
    alu_op    = 4'b1111;
    alu_right = 1'b0;
    alu_arith = 1'b0;
    alu_ai    = '0;
    alu_bi    = '0;
    alu_ci    = 1'b0;
    hi_sel    = 1'b0;
    if (state == S0 || state == S1) begin
      hi_sel = (state == S0) ? dec_right : ~dec_right;
      alu_ai = hi_sel ? a_q[15:8] : a_q[7:0];
      if (!dec_nop) begin
        alu_op    = dec_op;
        alu_right = dec_right;
        alu_arith = dec_asr && (state == S0);
        if (dec_use_b)
          alu_bi = hi_sel ? b_q[15:8] : b_q[7:0];
        alu_ci = (state == S0) ? dec_ci0 : alu_co;
      end
    end
  end

  always_comb begin
    if (dec_nop)
      word = a_q;
    else if (dec_right)
      word = {byte0_q, alu_out};
    else
      word = {alu_out, byte0_q};
    word_c = dec_nop ? c_q : alu_co;
    word_v = dec_addsub & alu_v;
  end

  always_comb begin
    state_next = state;
    if (rdy) begin
      case (state)
        IDLE:    if (start) state_next = S0;
        S0:      state_next = S1;
        S1:      state_next = S2;
        S2:      state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      c_out   <= 1'b0;
      v_out   <= 1'b0;
      n_out   <= 1'b0;
      z_out   <= 1'b0;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      byte0_q <= '0;
    end else if (rdy) begin
      state <= state_next;
      done  <= (state == S2);
      if (state == IDLE && start) begin
        cmd_q <= cmd;
        a_q   <= a_in;
        b_q   <= b_in;
        c_q   <= c_in;
      end
      if (state == S1)
        byte0_q <= alu_out;
      if (state == S2) begin
        result <= word;
        c_out  <= word_c;
        v_out  <= word_v;
        n_out  <= word[15];
        z_out  <= (word == 16'h0000);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu16_seq_65ce02.sv
// Bench for alu16_seq_65ce02: external 8-bit ALU model plus a 16-bit word reference.
module tb_alu16_seq_65ce02;

  logic        clk = 1'b0;
  logic        reset, rdy, start;
  logic [3:0]  cmd;
  logic [15:0] a_in, b_in;
  logic        c_in;
  logic [3:0]  alu_op;
  logic        alu_right, alu_arith;
  logic [7:0]  alu_ai, alu_bi;
  logic        alu_ci;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_co = 1'b0;
  logic        alu_v = 1'b0;
  logic        busy, done;
  logic [15:0] result;
  logic        c_out, v_out, n_out, z_out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  alu16_seq_65ce02 dut (
    .clk(clk), .reset(reset), .rdy(rdy), .start(start), .cmd(cmd),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .alu_op(alu_op), .alu_right(alu_right), .alu_arith(alu_arith),
    .alu_ai(alu_ai), .alu_bi(alu_bi), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v),
    .busy(busy), .done(done), .result(result),
    .c_out(c_out), .v_out(v_out), .n_out(n_out), .z_out(z_out)
  );

  always #5 clk = ~clk;

  // 8-bit ALU: returns {v, co, out}.
  function automatic logic [9:0] alu_eval(input logic [3:0] op, input logic right,
                                          input logic arith, input logic [7:0] ai,
                                          input logic [7:0] bi, input logic ci);
    logic [8:0] s;
    logic [7:0] bb;
    logic       v;
    s  = '0;
    bb = bi;
    v  = 1'b0;
    case (op)
      4'b0011, 4'b0111: begin
        if (op == 4'b0111) bb = ~bi;
        s = {1'b0, ai} + {1'b0, bb} + {8'd0, ci};
        v = (ai[7] == bb[7]) && (s[7] != ai[7]);
      end
      4'b1011: s = {ai, ci};
      4'b1111: s = right ? {ai[0], (arith ? ai[7] : ci), ai[7:1]} : {1'b0, ai};
      default: s = {1'b0, ai};
    endcase
    return {v, s};
  endfunction

  always @(posedge clk)
    if (rdy) {alu_v, alu_co, alu_out} <= alu_eval(alu_op, alu_right, alu_arith, alu_ai, alu_bi, alu_ci);

  // Word-level reference: returns {c, v, result}.
  function automatic logic [17:0] ref16(input logic [3:0] op, input logic [15:0] a,
                                       input logic [15:0] b, input logic ci);
    logic [16:0] s;
    logic [15:0] r;
    logic        co, v;
    v = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        r = s[15:0]; co = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + {16'd0, ci};
        r = s[15:0]; co = s[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'd2: begin r = a + 16'd1; co = (a == 16'hFFFF); end
      4'd3: begin r = a - 16'd1; co = (a != 16'h0000); end
      4'd4: begin r = {a[14:0], 1'b0}; co = a[15]; end
      4'd5: begin r = {a[14:0], ci}; co = a[15]; end
      4'd6: begin r = {1'b0, a[15:1]}; co = a[0]; end
      4'd7: begin r = {ci, a[15:1]}; co = a[0]; end
`ifdef ALU16_SEQ_ASR_EN
      4'd8: begin r = {a[15], a[15:1]}; co = a[0]; end
`endif
      default: begin r = a; co = ci; end
    endcase
    return {co, v, r};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input int stall);
    logic [17:0] e;
    int cyc;
    e = ref16(op, a, b, ci);
    cmd = op; a_in = a; b_in = b; c_in = ci; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    cmd = 4'($urandom); a_in = 16'($urandom); b_in = 16'($urandom); c_in = 1'($urandom);
    check("busy_s0", 32'(busy), 32'd1);
    if (stall > 0) begin
      tick(); cyc++;
      rdy = 1'b0;
      repeat (stall) begin tick(); cyc++; end
      rdy = 1'b1;
    end
    while (!done && cyc < 20) begin tick(); cyc++; end
    check("latency", 32'(cyc), 32'(4 + stall));
    check("result", 32'(result), 32'(e[15:0]));
    check("c_out", 32'(c_out), 32'(e[17]));
    check("v_out", 32'(v_out), 32'(e[16]));
    check("n_out", 32'(n_out), 32'(e[15]));
    check("z_out", 32'(z_out), 32'(e[15:0] == 16'h0000));
    check("busy_done", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    logic saw_done;
    rdy = 1'b1; start = 1'b0; cmd = '0; a_in = '0; b_in = '0; c_in = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({c_out, v_out, n_out, z_out}), 32'd0);
    check("rst_busy_done", 32'({busy, done}), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'hF);
    check("rst_alu_ctl", 32'({alu_right, alu_arith, alu_ci}), 32'd0);
    check("rst_alu_bytes", 32'({alu_ai, alu_bi}), 32'd0);

    do_op(4'd0, 16'h12FF, 16'h0001, 1'b0, 0);
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("result_held", 32'(result), 32'h1300);

    do_op(4'd1, 16'h0000, 16'h0001, 1'b1, 0);
    do_op(4'd1, 16'h8000, 16'h0001, 1'b1, 0);
    do_op(4'd2, 16'hFFFF, 16'h0000, 1'b0, 0);
    do_op(4'd3, 16'h0000, 16'h0000, 1'b0, 0);
    do_op(4'd7, 16'h0001, 16'h0000, 1'b1, 0);
    do_op(4'd5, 16'h8000, 16'h0000, 1'b0, 0);
    do_op(4'd0, 16'h12FF, 16'h0001, 1'b0, 2);
    do_op(4'd8, 16'h8002, 16'h0000, 1'b1, 0);
    do_op(4'd8, 16'h8002, 16'h0000, 1'b0, 0);
    do_op(4'd6, 16'h8001, 16'h0000, 1'b1, 0);
    do_op(4'd4, 16'hC0DE, 16'h0000, 1'b1, 0);
    do_op(4'd15, 16'hBEEF, 16'h1234, 1'b1, 0);

    // start while busy must be ignored and not queued
    cmd = 4'd0; a_in = 16'h0001; b_in = 16'h0002; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cmd = 4'd2; a_in = 16'h0005; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("busy_start_done", 32'(done), 32'd1);
    check("busy_start_result", 32'(result), 32'h0003);
    tick();
    check("busy_start_noqueue", 32'({busy, done}), 32'd0);

    // reset during S1 aborts the operation
    cmd = 4'd0; a_in = 16'h4444; b_in = 16'h1111; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    saw_done = done;
    repeat (6) begin tick(); saw_done |= done; end
    check("abort_no_done", 32'(saw_done), 32'd0);
    check("abort_result_kept", 32'(result), 32'd0);

    for (int i = 0; i < 300; i++) begin
      do_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom), 1'($urandom),
            $urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
